// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single data memory.
//
// Each granted access takes three cycles: IDLE (sample/arbitrate), ISSUE (drive memory),
// DONE (one-cycle ack to the winner). Out-of-range accesses and stores to address 0
// raise err, never write and return zero data.
//
// Optional feature macro: MEM_ARB_ALIGN_CHECK_EN
//   defined   - misaligned half/word accesses also raise err
//   undefined - misaligned accesses go to the memory unchanged
//
// Ports:
//   clock, reset               system clock, asynchronous active-high reset
//   req0/1, addr0/1, wdata0/1  per-port request, byte address and store data
//   size0/1, we0/1             access code (LB_SB/LH_SH/LW_SW/LBU/LHU) and store flag
//   ack0/1, err0/1, rdata0/1   per-port completion pulse, error flag, load data
//   addr_mem, wdata_mem        memory address and store data (driven only in ISSUE)
//   rd_wr_mem, mem_wr          memory access code and write enable
//   rdata_mem                  combinational read data from the memory
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 101
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  size0,
  input  logic [2:0]  size1,
  input  logic        we0,
  input  logic        we1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] addr_mem,
  output logic [31:0] wdata_mem,
  output logic [2:0]  rd_wr_mem,
  output logic        mem_wr,
  input  logic [31:0] rdata_mem
);

  localparam logic [2:0] LB_SB = 3'b000;
  localparam logic [2:0] LH_SH = 3'b001;
  localparam logic [2:0] LW_SW = 3'b010;
  localparam logic [2:0] LBU   = 3'b100;
  localparam logic [2:0] LHU   = 3'b101;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic        port_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        any_req, grant, take;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        range_err, zero_store_err, align_err, err;
  logic [31:0] cap_data;

  assign any_req = req0 | req1;
  // On a tie the port not granted last wins; otherwise the lone requester wins.
  assign grant   = (req0 && req1) ? ~last_grant_q : ~req0;
  assign take    = (state_q == StIdle) && any_req;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Winning request is frozen here; later payload changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      port_q       <= 1'b0;
    end else if (take) begin
      last_grant_q <= grant;
      port_q       <= grant;
      addr_q       <= grant ? addr1  : addr0;
      wdata_q      <= grant ? wdata1 : wdata0;
      size_q       <= grant ? size1  : size0;
      we_q         <= grant ? we1    : we0;
    end
  end

  // Error checks on the latched request; 33-bit end address cannot wrap.
  always_comb begin
    nbytes = 3'd4;
    case (size_q)
      LB_SB, LBU: nbytes = 3'd1;
      LH_SH, LHU: nbytes = 3'd2;
      default:    nbytes = 3'd4;
    endcase
  end

  assign end_addr       = {1'b0, addr_q} + {30'd0, nbytes} - 33'd1;
  assign range_err      = end_addr > (33'(MEM_BYTES) - 33'd1);
  assign zero_store_err = we_q && (addr_q == 32'd0);

`ifdef MEM_ARB_ALIGN_CHECK_EN
  always_comb begin
    align_err = 1'b0;
    case (size_q)
      LH_SH, LHU: align_err = addr_q[0];
      LW_SW:      align_err = (addr_q[1:0] != 2'b00);
      default:    align_err = 1'b0;
    endcase
  end
`else
  assign align_err = 1'b0;
`endif

  assign err      = range_err | zero_store_err | align_err;
  assign cap_data = (!we_q && !err) ? rdata_mem : 32'd0;

  // Only the winner's data register is updated; the loser's holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == StIssue) begin
      if (port_q) begin
        rdata1_q <= cap_data;
      end else begin
        rdata0_q <= cap_data;
      end
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    addr_mem  = '0;
    wdata_mem = '0;
    rd_wr_mem = '0;
    mem_wr    = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    unique case (state_q)
      StIssue: begin
        addr_mem  = addr_q;
        wdata_mem = wdata_q;
        rd_wr_mem = size_q;
        mem_wr    = we_q & ~err;
      end
      StDone: begin
        ack0 = ~port_q;
        ack1 = port_q;
        err0 = ~port_q & err;
        err1 = port_q & err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model behind it.
module tb_mem_arbiter;

  localparam int unsigned MemBytes = 101;
  localparam logic [2:0] LB_SB = 3'b000;
  localparam logic [2:0] LH_SH = 3'b001;
  localparam logic [2:0] LW_SW = 3'b010;
  localparam logic [2:0] LBU   = 3'b100;
  localparam logic [2:0] LHU   = 3'b101;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [2:0]  size0 = '0, size1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1, addr_mem, wdata_mem;
  logic [2:0]  rd_wr_mem;
  logic        mem_wr;
  logic [31:0] rdata_mem;

  int n_checks = 0;
  int n_fail   = 0;
  int both_acks = 0;

  logic [7:0] mem [MemBytes] = '{default: 8'h00};
  int         mem_ver = 0;

  mem_arbiter #(.MEM_BYTES(MemBytes)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .size0(size0), .size1(size1),
    .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .rd_wr_mem(rd_wr_mem), .mem_wr(mem_wr),
    .rdata_mem(rdata_mem)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (a < MemBytes) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] sz);
    logic [7:0] b0, b1, b2, b3;
    b0 = byte_at(a);
    b1 = byte_at(a + 32'd1);
    b2 = byte_at(a + 32'd2);
    b3 = byte_at(a + 32'd3);
    case (sz)
      LB_SB:   return {{24{b0[7]}}, b0};
      LBU:     return {24'd0, b0};
      LH_SH:   return {{16{b1[7]}}, b1, b0};
      LHU:     return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(addr_mem or rd_wr_mem or mem_ver) rdata_mem = mem_rd(addr_mem, rd_wr_mem);

  always @(posedge clock) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        int nb;
        nb = (rd_wr_mem == LB_SB) ? 1 : (rd_wr_mem == LH_SH) ? 2 : 4;
        if (i < nb && (int'(addr_mem) + i) < int'(MemBytes))
          mem[int'(addr_mem) + i] <= wdata_mem[8*i +: 8];
      end
      mem_ver <= mem_ver + 1;
    end
  end

  always @(negedge clock) if (ack0 && ack1) both_acks++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on one port; mw bit i = mem_wr seen at the i-th falling edge after the drive.
  task automatic access(input int port, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic e, output logic [31:0] rd, output int lat,
                        output logic [3:0] mw);
    bit got;
    got = 0; e = 1'b0; rd = '0; lat = 0; mw = '0;
    @(posedge clock); #1;
    if (port == 0) begin
      req0 = 1'b1; we0 = w; size0 = sz; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = w; size1 = sz; addr1 = a; wdata1 = wd;
    end
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clock);
      if (i < 4 && mem_wr) mw[i] = 1'b1;
      if (port == 0 && ack0) begin got = 1; lat = i; e = err0; rd = rdata0; end
      if (port == 1 && ack1) begin got = 1; lat = i; e = err1; rd = rdata1; end
    end
    // Drop the request in the ack cycle.
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!got) check("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e;
    logic [31:0] rd;
    int          lat;
    logic [3:0]  mw;
    int          order [4];
    int          n;
    int          acks;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_err", {err1, err0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_addr_mem", addr_mem, 32'd0);
    reset = 1'b0;

    // Word store then load; ack in the third cycle counting the request cycle
    access(0, 1'b1, LW_SW, 32'd8, 32'hDEADBEEF, e, rd, lat, mw);
    check("sw8_err", 32'(e), 32'd0);
    check("sw8_memwr_issue_only", 32'(mw), 32'b0100);
    check("sw8_latency", 32'(lat), 32'd3);
    access(0, 1'b0, LW_SW, 32'd8, 32'd0, e, rd, lat, mw);
    check("lw8_rdata", rd, 32'hDEADBEEF);
    check("lw8_err", 32'(e), 32'd0);
    check("lw8_latency", 32'(lat), 32'd3);
    check("lw8_no_memwr", 32'(mw), 32'd0);

    // Round robin: both held, fresh reset so port 0 wins the first tie
    pulse_reset();
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; size0 = LBU;   addr0 = 32'd8;
    req1 = 1'b1; we1 = 1'b0; size1 = LW_SW; addr1 = 32'd8;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clock);
      if (ack0 && n < 4) begin order[n] = 0; n++; end
      if (ack1 && n < 4) begin order[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_grants", 32'(n), 32'd4);
    check("rr_g0", 32'(order[0]), 32'd0);
    check("rr_g1", 32'(order[1]), 32'd1);
    check("rr_g2", 32'(order[2]), 32'd0);
    check("rr_g3", 32'(order[3]), 32'd1);
    check("rr_rdata0", rdata0, 32'h000000EF);
    check("rr_rdata1", rdata1, 32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads; port 1 data must hold
    access(0, 1'b1, LB_SB, 32'd8, 32'h00000080, e, rd, lat, mw);
    check("sb8_err", 32'(e), 32'd0);
    access(0, 1'b0, LB_SB, 32'd8, 32'd0, e, rd, lat, mw);
    check("lb8_rdata", rd, 32'hFFFFFF80);
    access(0, 1'b0, LBU, 32'd8, 32'd0, e, rd, lat, mw);
    check("lbu8_rdata", rd, 32'h00000080);
    check("rdata1_hold", rdata1, 32'hDEADBEEF);

    // Range and address-0 errors
    access(0, 1'b1, LW_SW, 32'd98, 32'h11223344, e, rd, lat, mw);
    check("sw98_err", 32'(e), 32'd1);
    check("sw98_no_memwr", 32'(mw), 32'd0);
    check("sw98_mem_unchanged", mem_rd(32'd97, LW_SW), 32'd0);
    access(1, 1'b1, LB_SB, 32'd0, 32'h000000AA, e, rd, lat, mw);
    check("sb0_err", 32'(e), 32'd1);
    check("sb0_no_memwr", 32'(mw), 32'd0);
    check("sb0_mem_unchanged", mem_rd(32'd0, LBU), 32'd0);
    check("sb0_rdata", rd, 32'd0);
    // Last valid byte is accepted; a half there runs past the end
    access(1, 1'b1, LB_SB, 32'd100, 32'h0000005A, e, rd, lat, mw);
    check("sb100_err", 32'(e), 32'd0);
    check("sb100_memwr", 32'(mw), 32'b0100);
    access(1, 1'b0, LBU, 32'd100, 32'd0, e, rd, lat, mw);
    check("lbu100_rdata", rd, 32'h0000005A);
    access(1, 1'b0, LHU, 32'd100, 32'd0, e, rd, lat, mw);
    check("lhu100_err", 32'(e), 32'd1);
    check("lhu100_rdata", rd, 32'd0);
    access(0, 1'b0, LW_SW, 32'd98, 32'd0, e, rd, lat, mw);
    check("lw98_err", 32'(e), 32'd1);

    // Misaligned half load at 9: bytes 9,10 = BE,AD
    access(0, 1'b0, LH_SH, 32'd9, 32'd0, e, rd, lat, mw);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("lh9_err", 32'(e), 32'd1);
    check("lh9_rdata", rd, 32'd0);
`else
    check("lh9_err", 32'(e), 32'd0);
    check("lh9_rdata", rd, 32'hFFFFADBE);
`endif

    // Reset during ISSUE of a store
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; size0 = LW_SW; addr0 = 32'd20; wdata0 = 32'h12345678;
    @(negedge clock);
    @(negedge clock);
    check("rst_mid_memwr_before", 32'(mem_wr), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_memwr_after", 32'(mem_wr), 32'd0);
    check("rst_mid_addr_mem", addr_mem, 32'd0);
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (ack0 || ack1) acks++;
    end
    check("rst_mid_no_ack", 32'(acks), 32'd0);
    check("rst_mid_mem_unchanged", mem_rd(32'd20, LW_SW), 32'd0);
    access(1, 1'b0, LW_SW, 32'd8, 32'd0, e, rd, lat, mw);
    check("post_rst_rdata", rd, 32'hDEADBE80);
    check("post_rst_err", 32'(e), 32'd0);
    check("post_rst_latency", 32'(lat), 32'd3);

    check("never_two_acks", 32'(both_acks), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
